// File: rtl/ls_mem_ctrl_if.sv
// Load/store controller port bundle: MEM-stage request, data-side bus and response.
// The controller uses the slave modport; the MEM stage / bus environment uses master.
interface ls_mem_ctrl_if #(
    parameter int PC_SZ = 32
);
    logic             req_valid_in;
    logic             req_ready_out;
    logic             req_rw_in;
    logic [PC_SZ-1:0] req_addr_in;
    logic [2:0]       req_size_in;
    logic             req_zero_ext_in;
    logic             req_mis_in;
    logic [31:0]      req_st_data_in;

    logic             bus_req_out;
    logic             bus_rw_out;
    logic [PC_SZ-1:0] bus_addr_out;
    logic [3:0]       bus_be_out;
    logic [31:0]      bus_wr_data_out;
    logic             bus_ack_in;
    logic             bus_err_in;
    logic [31:0]      bus_rd_data_in;

    logic             rsp_valid_out;
    logic [31:0]      rsp_ld_data_out;
    logic             rsp_exc_out;
    logic [3:0]       rsp_exc_cause_out;
    logic [PC_SZ-1:0] rsp_exc_addr_out;

    modport slave (
        input  req_valid_in, req_rw_in, req_addr_in, req_size_in, req_zero_ext_in,
               req_mis_in, req_st_data_in, bus_ack_in, bus_err_in, bus_rd_data_in,
        output req_ready_out, bus_req_out, bus_rw_out, bus_addr_out, bus_be_out,
               bus_wr_data_out, rsp_valid_out, rsp_ld_data_out, rsp_exc_out,
               rsp_exc_cause_out, rsp_exc_addr_out
    );

    modport master (
        output req_valid_in, req_rw_in, req_addr_in, req_size_in, req_zero_ext_in,
               req_mis_in, req_st_data_in, bus_ack_in, bus_err_in, bus_rd_data_in,
        input  req_ready_out, bus_req_out, bus_rw_out, bus_addr_out, bus_be_out,
               bus_wr_data_out, rsp_valid_out, rsp_ld_data_out, rsp_exc_out,
               rsp_exc_cause_out, rsp_exc_addr_out
    );
endinterface

// File: rtl/ls_mem_ctrl.sv
// MEM-stage load/store sequencer onto the data bus: lane shifting, byte enables,
// load alignment/extension, misalignment, bus-error and bus-timeout exceptions.
// Optional feature macro: MISALIGNED_SPLIT_EN -- when defined, word-crossing accesses
// are split into two bus transfers instead of raising a misaligned exception.
module ls_mem_ctrl #(
    parameter int PC_SZ       = 32,
    parameter int BUS_TIMEOUT = 16
) (
    input  logic          clk_in,
    input  logic          reset_n_in,
    ls_mem_ctrl_if.slave  port
);
`ifdef MISALIGNED_SPLIT_EN
    localparam int LW = 8;   // lanes across two adjacent words
`else
    localparam int LW = 4;
`endif
    localparam int            CW      = $clog2(BUS_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2, RESP = 2'd3} state_t;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic              ready_r;
    logic              bus_req_r;
    logic              bus_rw_r;
    logic [PC_SZ-1:0]  bus_addr_r;
    logic [3:0]        bus_be_r;
    logic [31:0]       bus_wd_r;
    logic              rsp_valid_r;
    logic [31:0]       rsp_ld_r;
    logic              rsp_exc_r;
    logic [3:0]        rsp_cause_r;
    logic [PC_SZ-1:0]  rsp_exc_addr_r;
    logic              rw_r;
    logic [PC_SZ-1:0]  addr_r;
    logic [1:0]        sz_r;
    logic              zext_r;
`ifdef MISALIGNED_SPLIT_EN
    logic              split_r;
    logic [3:0]        be2_r;
    logic [31:0]       wd2_r;
    logic [31:0]       rd_lo_r;
    logic              split_s;
`endif

    logic [1:0]        sz_s;
    logic [LW-1:0]     mask_s;
    logic [LW-1:0]     be_full_s;
    logic [8*LW-1:0]   wd_full_s;
    logic [8*LW-1:0]   raw_s;
    logic [31:0]       ld_s;

    // Size encoding: 0 = byte, 1 = half, 2 = word (any other request size acts as word)
    function automatic logic [1:0] size_code(input logic [2:0] size);
        logic [1:0] code;
        case (size)
            3'd1:    code = 2'd0;
            3'd2:    code = 2'd1;
            default: code = 2'd2;
        endcase
        return code;
    endfunction

    // Shift raw lane data down to the access offset, then mask and extend to 32 bits
    function automatic logic [31:0] load_align(input logic [8*LW-1:0] raw, input logic [1:0] off,
                                               input logic [1:0] sz, input logic zext);
        logic [8*LW-1:0] sh;
        logic [31:0]     res;
        sh = raw >> {off, 3'b000};
        case (sz)
            2'd0:    res = zext ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1:    res = zext ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = sh[31:0];
        endcase
        return res;
    endfunction

    // Lane placement of the incoming request and alignment of the returning read data
    always_comb begin
        sz_s = size_code(port.req_size_in);
        case (sz_s)
            2'd0:    mask_s = LW'(8'h01);
            2'd1:    mask_s = LW'(8'h03);
            default: mask_s = LW'(8'h0F);
        endcase
        be_full_s = mask_s << port.req_addr_in[1:0];
        wd_full_s = (8*LW)'(port.req_st_data_in) << {port.req_addr_in[1:0], 3'b000};
`ifdef MISALIGNED_SPLIT_EN
        split_s = |be_full_s[7:4];
        if (state_r == ACC2) begin
            raw_s = {port.bus_rd_data_in, rd_lo_r};
        end else begin
            raw_s = {32'h00000000, port.bus_rd_data_in};
        end
`else
        raw_s = port.bus_rd_data_in;
`endif
        ld_s = load_align(raw_s, addr_r[1:0], sz_r, zext_r);
    end

    // Request/bus/response sequencer with all outputs registered
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            ready_r        <= 1'b1;
            bus_req_r      <= 1'b0;
            bus_rw_r       <= 1'b0;
            bus_addr_r     <= '0;
            bus_be_r       <= 4'h0;
            bus_wd_r       <= 32'h00000000;
            rsp_valid_r    <= 1'b0;
            rsp_ld_r       <= 32'h00000000;
            rsp_exc_r      <= 1'b0;
            rsp_cause_r    <= 4'h0;
            rsp_exc_addr_r <= '0;
            rw_r           <= 1'b0;
            addr_r         <= '0;
            sz_r           <= 2'd0;
            zext_r         <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            split_r        <= 1'b0;
            be2_r          <= 4'h0;
            wd2_r          <= 32'h00000000;
            rd_lo_r        <= 32'h00000000;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (port.req_valid_in) begin
                        ready_r <= 1'b0;
                        rw_r    <= port.req_rw_in;
                        addr_r  <= port.req_addr_in;
                        sz_r    <= sz_s;
                        zext_r  <= port.req_zero_ext_in;
`ifdef MISALIGNED_SPLIT_EN
                        split_r <= split_s;
                        be2_r   <= be_full_s[7:4];
                        wd2_r   <= wd_full_s[63:32];
                        begin
`else
                        if (port.req_mis_in) begin
                            state_r        <= RESP;
                            rsp_valid_r    <= 1'b1;
                            rsp_exc_r      <= 1'b1;
                            rsp_cause_r    <= port.req_rw_in ? 4'd6 : 4'd4;
                            rsp_exc_addr_r <= port.req_addr_in;
                            rsp_ld_r       <= 32'h00000000;
                        end else begin
`endif
                            state_r    <= ACC1;
                            cnt_r      <= '0;
                            bus_req_r  <= 1'b1;
                            bus_rw_r   <= port.req_rw_in;
                            bus_addr_r <= {port.req_addr_in[PC_SZ-1:2], 2'b00};
                            bus_be_r   <= be_full_s[3:0];
                            bus_wd_r   <= wd_full_s[31:0];
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACC1, ACC2: begin
                    if (port.bus_err_in || (!port.bus_ack_in && (cnt_r == CNT_MAX))) begin
                        // Access fault; error takes priority over ack
                        bus_req_r      <= 1'b0;
                        cnt_r          <= '0;
                        state_r        <= RESP;
                        rsp_valid_r    <= 1'b1;
                        rsp_exc_r      <= 1'b1;
                        rsp_cause_r    <= rw_r ? 4'd7 : 4'd5;
                        rsp_exc_addr_r <= addr_r;
                        rsp_ld_r       <= 32'h00000000;
                    end else if (port.bus_ack_in) begin
                        cnt_r <= '0;
`ifdef MISALIGNED_SPLIT_EN
                        if ((state_r == ACC1) && split_r) begin
                            // Second half: next word (wraps modulo 2^PC_SZ), remaining lanes
                            rd_lo_r    <= port.bus_rd_data_in;
                            state_r    <= ACC2;
                            bus_addr_r <= bus_addr_r + PC_SZ'(4);
                            bus_be_r   <= be2_r;
                            bus_wd_r   <= wd2_r;
                        end else begin
`else
                        begin
`endif
                            bus_req_r   <= 1'b0;
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_exc_r   <= 1'b0;
                            rsp_ld_r    <= rw_r ? 32'h00000000 : ld_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RESP: begin
                    state_r        <= IDLE;
                    ready_r        <= 1'b1;
                    rsp_valid_r    <= 1'b0;
                    rsp_exc_r      <= 1'b0;
                    rsp_cause_r    <= 4'h0;
                    rsp_exc_addr_r <= '0;
                    rsp_ld_r       <= 32'h00000000;
                end
                default: begin
                    state_r     <= IDLE;
                    ready_r     <= 1'b1;
                    bus_req_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign port.req_ready_out     = ready_r;
    assign port.bus_req_out       = bus_req_r;
    assign port.bus_rw_out        = bus_rw_r;
    assign port.bus_addr_out      = bus_addr_r;
    assign port.bus_be_out        = bus_be_r;
    assign port.bus_wr_data_out   = bus_wd_r;
    assign port.rsp_valid_out     = rsp_valid_r;
    assign port.rsp_ld_data_out   = rsp_ld_r;
    assign port.rsp_exc_out       = rsp_exc_r;
    assign port.rsp_exc_cause_out = rsp_exc_cause_map(rsp_cause_r);

    // Cause register is driven straight out; kept as a function for a single mapping point
    function automatic logic [3:0] rsp_exc_cause_map(input logic [3:0] cause);
        return cause;
    endfunction

    assign port.rsp_exc_addr_out  = rsp_exc_addr_r;
endmodule

// File: tb/tb_ls_mem_ctrl.sv
// Directed, table-driven bench for ls_mem_ctrl, plus hand-written reset-abort sequence.
// Expectations follow the MISALIGNED_SPLIT_EN build setting.
module tb_ls_mem_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ls_mem_ctrl_if #(.PC_SZ(32)) dif ();

    ls_mem_ctrl #(.PC_SZ(32), .BUS_TIMEOUT(16)) dut (
        .clk_in     (clk),
        .reset_n_in (rst_n),
        .port       (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        zext;
        logic        mis;
        logic [31:0] st;
        int          nx;     // bus transfers expected
        int          wt;     // wait cycles before responding to transfer 1
        int          fail;   // 0 ack, 1 err on xfer1, 2 err on xfer2, 3 never answer xfer1
        logic [31:0] rd1, rd2;
        logic [31:0] a1;  logic [3:0] be1; logic [31:0] wd1;
        logic [31:0] a2;  logic [3:0] be2; logic [31:0] wd2;
        logic [31:0] ld;
        logic        exc;
        logic [3:0]  cause;
        int          lat;    // negedges from accept to rsp_valid; 0 = unchecked
    } vec_t;

    vec_t vt [14];

    function automatic vec_t mk(logic rw, logic [31:0] addr, logic [2:0] size, logic zext,
                                logic mis, logic [31:0] st, int nx, int wt, int fail,
                                logic [31:0] rd1, logic [31:0] rd2,
                                logic [31:0] a1, logic [3:0] be1, logic [31:0] wd1,
                                logic [31:0] a2, logic [3:0] be2, logic [31:0] wd2,
                                logic [31:0] ld, logic exc, logic [3:0] cause, int lat);
        vec_t v;
        v.rw = rw; v.addr = addr; v.size = size; v.zext = zext; v.mis = mis; v.st = st;
        v.nx = nx; v.wt = wt; v.fail = fail; v.rd1 = rd1; v.rd2 = rd2;
        v.a1 = a1; v.be1 = be1; v.wd1 = wd1; v.a2 = a2; v.be2 = be2; v.wd2 = wd2;
        v.ld = ld; v.exc = exc; v.cause = cause; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  cyc;
        int  n;
        bit  stop;
        @(negedge clk);
        check($sformatf("v%0d_ready_idle", idx), 32'(dif.req_ready_out), 32'd1);
        dif.req_valid_in    = 1'b1;
        dif.req_rw_in       = v.rw;
        dif.req_addr_in     = v.addr;
        dif.req_size_in     = v.size;
        dif.req_zero_ext_in = v.zext;
        dif.req_mis_in      = v.mis;
        dif.req_st_data_in  = v.st;
        @(negedge clk);
        dif.req_valid_in = 1'b0;
        cyc  = 1;
        stop = 1'b0;
        for (int x = 1; x <= v.nx; x++) begin
            if (!stop) begin
                n = 0;
                while (!dif.bus_req_out && n < 40) begin @(negedge clk); cyc++; n++; end
                check($sformatf("v%0d_x%0d_bus_req", idx, x), 32'(dif.bus_req_out), 32'd1);
                check($sformatf("v%0d_x%0d_addr", idx, x), dif.bus_addr_out, (x == 1) ? v.a1 : v.a2);
                check($sformatf("v%0d_x%0d_be", idx, x), 32'(dif.bus_be_out), 32'((x == 1) ? v.be1 : v.be2));
                check($sformatf("v%0d_x%0d_rw", idx, x), 32'(dif.bus_rw_out), 32'(v.rw));
                if (v.rw) begin
                    check($sformatf("v%0d_x%0d_wd", idx, x), dif.bus_wr_data_out, (x == 1) ? v.wd1 : v.wd2);
                end
                if (v.fail == 3 && x == 1) begin
                    n = 0;
                    while (dif.bus_req_out && n < 40) begin n++; @(negedge clk); cyc++; end
                    check($sformatf("v%0d_timeout_cycles", idx), 32'(n), 32'd16);
                    stop = 1'b1;
                end else begin
                    if (x == 1) begin
                        repeat (v.wt) begin @(negedge clk); cyc++; end
                    end
                    if ((v.fail == 1 && x == 1) || (v.fail == 2 && x == 2)) begin
                        dif.bus_err_in = 1'b1;
                        stop = 1'b1;
                    end else begin
                        dif.bus_ack_in = 1'b1;
                    end
                    dif.bus_rd_data_in = (x == 1) ? v.rd1 : v.rd2;
                    @(negedge clk);
                    cyc++;
                    dif.bus_ack_in     = 1'b0;
                    dif.bus_err_in     = 1'b0;
                    dif.bus_rd_data_in = 32'h00000000;
                end
            end
        end
        n = 0;
        while (!dif.rsp_valid_out && n < 40) begin @(negedge clk); cyc++; n++; end
        check($sformatf("v%0d_rsp_valid", idx), 32'(dif.rsp_valid_out), 32'd1);
        check($sformatf("v%0d_bus_req_idle", idx), 32'(dif.bus_req_out), 32'd0);
        check($sformatf("v%0d_ld_data", idx), dif.rsp_ld_data_out, v.ld);
        check($sformatf("v%0d_exc", idx), 32'(dif.rsp_exc_out), 32'(v.exc));
        if (v.exc) begin
            check($sformatf("v%0d_cause", idx), 32'(dif.rsp_exc_cause_out), 32'(v.cause));
            check($sformatf("v%0d_exc_addr", idx), dif.rsp_exc_addr_out, v.addr);
        end
        if (v.lat != 0) begin
            check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.lat));
        end
        @(negedge clk);
        check($sformatf("v%0d_rsp_pulse", idx), 32'(dif.rsp_valid_out), 32'd0);
        check($sformatf("v%0d_ready_back", idx), 32'(dif.req_ready_out), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen_rsp;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        dif.req_valid_in = 1'b0; dif.req_rw_in = 1'b0; dif.req_addr_in = 32'h0;
        dif.req_size_in = 3'd0; dif.req_zero_ext_in = 1'b0; dif.req_mis_in = 1'b0;
        dif.req_st_data_in = 32'h0; dif.bus_ack_in = 1'b0; dif.bus_err_in = 1'b0;
        dif.bus_rd_data_in = 32'h0;

        //          rw  addr          sz  ze mis st            nx wt f  rd1           rd2           a1            be1    wd1           a2            be2    wd2           ld            exc cause lat
        vt[0]  = mk(0, 32'h00000100, 3'd4, 0, 0, 32'h0,        1, 3, 0, 32'hDEADBEEF, 32'h0,        32'h00000100, 4'hF, 32'h0,        32'h0,        4'h0, 32'h0,        32'hDEADBEEF, 0, 4'd0, 5);
        vt[1]  = mk(0, 32'h00000203, 3'd1, 0, 0, 32'h0,        1, 0, 0, 32'h80123456, 32'h0,        32'h00000200, 4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFFFF80, 0, 4'd0, 2);
        vt[2]  = mk(0, 32'h00000203, 3'd1, 1, 0, 32'h0,        1, 0, 0, 32'h80123456, 32'h0,        32'h00000200, 4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00000080, 0, 4'd0, 2);
        vt[5]  = mk(1, 32'h00000500, 3'd4, 0, 0, 32'h11223344, 1, 0, 1, 32'h0,        32'h0,        32'h00000500, 4'hF, 32'h11223344, 32'h0,        4'h0, 32'h0,        32'h0,        1, 4'd7, 0);
        vt[6]  = mk(0, 32'h00000600, 3'd4, 0, 0, 32'h0,        1, 0, 3, 32'h0,        32'h0,        32'h00000600, 4'hF, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 4'd5, 0);
        vt[7]  = mk(0, 32'h00000702, 3'd2, 0, 0, 32'h0,        1, 0, 0, 32'h80017777, 32'h0,        32'h00000700, 4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF8001, 0, 4'd0, 2);
        vt[8]  = mk(0, 32'h00000702, 3'd2, 1, 0, 32'h0,        1, 0, 0, 32'h80017777, 32'h0,        32'h00000700, 4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00008001, 0, 4'd0, 2);
        vt[9]  = mk(1, 32'h00000801, 3'd1, 0, 0, 32'h000000A5, 1, 1, 0, 32'h0,        32'h0,        32'h00000800, 4'h2, 32'h0000A500, 32'h0,        4'h0, 32'h0,        32'h0,        0, 4'd0, 3);
        vt[11] = mk(0, 32'h00000900, 3'd0, 0, 0, 32'h0,        1, 0, 0, 32'h0BADF00D, 32'h0,        32'h00000900, 4'hF, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0BADF00D, 0, 4'd0, 2);
`ifdef MISALIGNED_SPLIT_EN
        vt[3]  = mk(1, 32'h00000301, 3'd2, 0, 1, 32'h00001234, 1, 0, 0, 32'h0,        32'h0,        32'h00000300, 4'h6, 32'h00123400, 32'h0,        4'h0, 32'h0,        32'h0,        0, 4'd0, 2);
        vt[4]  = mk(0, 32'h00000403, 3'd4, 0, 1, 32'h0,        2, 0, 0, 32'hAA112233, 32'h99CCBBDD, 32'h00000400, 4'h8, 32'h0,        32'h00000404, 4'h7, 32'h0,        32'hCCBBDDAA, 0, 4'd0, 3);
        vt[10] = mk(1, 32'hFFFFFFFE, 3'd4, 0, 1, 32'h11223344, 2, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 4'hC, 32'h33440000, 32'h00000000, 4'h3, 32'h00001122, 32'h0,        0, 4'd0, 3);
        vt[12] = mk(0, 32'h00000803, 3'd2, 0, 1, 32'h0,        2, 0, 2, 32'h11000000, 32'h0,        32'h00000800, 4'h8, 32'h0,        32'h00000804, 4'h1, 32'h0,        32'h0,        1, 4'd5, 0);
        vt[13] = mk(0, 32'h00000901, 3'd2, 0, 1, 32'h0,        1, 0, 0, 32'h00F00D00, 32'h0,        32'h00000900, 4'h6, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFFF00D, 0, 4'd0, 2);
`else
        vt[3]  = mk(1, 32'h00000301, 3'd2, 0, 1, 32'h00001234, 0, 0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 4'd6, 1);
        vt[4]  = mk(0, 32'h00000403, 3'd4, 0, 1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 4'd4, 1);
        vt[10] = mk(1, 32'hFFFFFFFE, 3'd4, 0, 1, 32'h11223344, 0, 0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 4'd6, 1);
        vt[12] = mk(0, 32'h00000803, 3'd2, 0, 1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 4'd4, 1);
        vt[13] = mk(0, 32'h00000901, 3'd2, 0, 1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 4'd4, 1);
`endif

        // Reset state
        #12;
        check("rst_ready", 32'(dif.req_ready_out), 32'd1);
        check("rst_bus_req", 32'(dif.bus_req_out), 32'd0);
        check("rst_bus_be", 32'(dif.bus_be_out), 32'd0);
        check("rst_rsp_valid", 32'(dif.rsp_valid_out), 32'd0);
        check("rst_rsp_exc", 32'(dif.rsp_exc_out), 32'd0);
        check("rst_ld_data", dif.rsp_ld_data_out, 32'd0);
        #11;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vt[i]);
        end

        // Reset while a bus request is outstanding
        @(negedge clk);
        dif.req_valid_in = 1'b1; dif.req_rw_in = 1'b0; dif.req_addr_in = 32'h00000A00;
        dif.req_size_in = 3'd4; dif.req_mis_in = 1'b0; dif.req_zero_ext_in = 1'b0;
        @(negedge clk);
        dif.req_valid_in = 1'b0;
        check("abort_bus_req_before", 32'(dif.bus_req_out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_bus_req_async", 32'(dif.bus_req_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_rsp = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (dif.rsp_valid_out) seen_rsp = 1'b1;
        end
        check("abort_no_rsp", 32'(seen_rsp), 32'd0);
        check("abort_ready", 32'(dif.req_ready_out), 32'd1);
        run_vec(100, vt[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
